// File: rtl/circ_shift_reg_16bit_if.sv
// Pattern bus for the circular shift register: the parallel load controls and
// the observed register state plus its serial output bit.
interface circ_shift_reg_16bit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] load_in;
    logic             load;
    logic             shift_out;
    logic [WIDTH-1:0] q;

    modport master (
        output load_in,
        output load,
        input  shift_out,
        input  q
    );

    modport slave (
        input  load_in,
        input  load,
        output shift_out,
        output q
    );
endinterface

// File: rtl/circ_shift_reg_16bit.sv
// Parallel-load circular shift register used as a repeating pulse/gap pattern
// generator; the output-end bit is presented on shift_out.
module circ_shift_reg_16bit #(
    parameter int WIDTH    = 16,
    parameter int ROT_LEFT = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    circ_shift_reg_16bit_if.slave  bus
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] rot_w;

    // Each bit takes its neighbour toward the input end; the far end wraps around.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rot
            if (ROT_LEFT != 0) begin : g_left
                assign rot_w[gi] = r_q[(gi + WIDTH - 1) % WIDTH];
            end else begin : g_right
                assign rot_w[gi] = r_q[(gi + 1) % WIDTH];
            end
        end
    endgenerate

    always_comb begin
        r_d = rot_w;
        if (bus.load) begin
            r_d = bus.load_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    assign bus.q = r_q;

    generate
        if (ROT_LEFT != 0) begin : g_out_msb
            assign bus.shift_out = r_q[WIDTH-1];
        end else begin : g_out_lsb
            assign bus.shift_out = r_q[0];
        end
    endgenerate
endmodule

// File: tb/tb_circ_shift_reg_16bit.sv
// Bench for the circular shift register: runs a left- and a right-rotating
// instance side by side from the same stimulus.
module tb_circ_shift_reg_16bit;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    circ_shift_reg_16bit_if #(.WIDTH(16)) bus_l ();
    circ_shift_reg_16bit_if #(.WIDTH(16)) bus_r ();

    circ_shift_reg_16bit #(.WIDTH(16), .ROT_LEFT(1)) dut_l (
        .clock (clock),
        .reset (reset),
        .bus   (bus_l.slave)
    );

    circ_shift_reg_16bit #(.WIDTH(16), .ROT_LEFT(0)) dut_r (
        .clock (clock),
        .reset (reset),
        .bus   (bus_r.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference values held as plain integers and rotated arithmetically.
    int unsigned model_l = 0;
    int unsigned model_r = 0;

    typedef struct {
        logic        rst;
        logic        ld;
        logic [15:0] din;
        logic [15:0] exp_ql;
        logic        exp_sol;
        logic [15:0] exp_qr;
        logic        exp_sor;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic rst, input logic ld, input logic [15:0] din);
        @(negedge clock);
        reset         = rst;
        bus_l.load    = ld;
        bus_r.load    = ld;
        bus_l.load_in = din;
        bus_r.load_in = din;
        @(posedge clock);
        if (rst) begin
            model_l = 0;
            model_r = 0;
        end else if (ld) begin
            model_l = din;
            model_r = din;
        end else begin
            model_l = (model_l * 2) % 65536 + model_l / 32768;
            model_r = model_r / 2 + (model_r % 2) * 32768;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_ql"}, bus_l.q, model_l);
        check({tag, "_sol"}, bus_l.shift_out, model_l / 32768);
        check({tag, "_qr"}, bus_r.q, model_r);
        check({tag, "_sor"}, bus_r.shift_out, model_r % 2);
    endtask

    initial begin
        reset         = 1'b1;
        bus_l.load    = 1'b0;
        bus_r.load    = 1'b0;
        bus_l.load_in = '0;
        bus_r.load_in = '0;

        //           rst   ld    din      ql       sol   qr       sor
        vecs[0]  = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 16'h8080, 16'h8080, 1'b1, 16'h8080, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 16'h0101, 1'b0, 16'h4040, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 16'hA5C3, 16'hA5C3, 1'b1, 16'hA5C3, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h4B87, 1'b0, 16'hD2E1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h970E, 1'b1, 16'hE970, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 16'h0000, 16'h2E1D, 1'b0, 16'h74B8, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 16'h00FF, 16'h00FF, 1'b0, 16'h00FF, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 16'h8080, 16'h8080, 1'b1, 16'h8080, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};

        for (int i = 0; i < 17; i++) begin
            tick(vecs[i].rst, vecs[i].ld, vecs[i].din);
            check($sformatf("vec%0d_ql", i), bus_l.q, vecs[i].exp_ql);
            check($sformatf("vec%0d_sol", i), bus_l.shift_out, vecs[i].exp_sol);
            check($sformatf("vec%0d_qr", i), bus_r.q, vecs[i].exp_qr);
            check($sformatf("vec%0d_sor", i), bus_r.shift_out, vecs[i].exp_sor);
        end

        // Pulse train from 0x8080: period 8 on both rotation directions.
        tick(1'b0, 1'b1, 16'h8080);
        check("pulse_load_sol", bus_l.shift_out, 1);
        for (int k = 1; k <= 50; k++) begin
            tick(1'b0, 1'b0, 16'h0000);
            check($sformatf("pulse%0d_sol", k), bus_l.shift_out, (k % 8 == 0) ? 1 : 0);
            check($sformatf("pulse%0d_sor", k), bus_r.shift_out, (k % 8 == 7) ? 1 : 0);
        end

        // Walking one: full wrap returns the loaded value.
        tick(1'b0, 1'b1, 16'h0001);
        for (int k = 1; k <= 16; k++) begin
            tick(1'b0, 1'b0, 16'h0000);
            check($sformatf("walk%0d_ql", k), bus_l.q, (32'd1 << (k % 16)));
            check($sformatf("walk%0d_sol", k), bus_l.shift_out, (k == 15) ? 1 : 0);
        end

        // Held load keeps reloading, output pinned to load_in's end bit.
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b1, 16'h7FFE);
            check_model($sformatf("hold%0d", k));
            check($sformatf("hold%0d_sol_const", k), bus_l.shift_out, 0);
        end

        // Reset mid-rotation.
        tick(1'b0, 1'b1, 16'h8080);
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 16'h0000);
        tick(1'b1, 1'b0, 16'h0000);
        check("midrst_ql", bus_l.q, 0);
        check("midrst_qr", bus_r.q, 0);

        // Randomised traffic against the reference model.
        for (int k = 0; k < 300; k++) begin
            tick(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                 16'($urandom()));
            check_model($sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
